program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 36 +++
 rtl/program_loader_word_assembler.sv | 55 +++++
 rtl/program_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: command codes, field widths and
// the loader FSM state encoding.
// Optional feature macro: LOADER_CHECKSUM_EN adds the StMCk checksum state.
package loader_pkg;

  localparam int unsigned DataWidth   = 16;
  localparam int unsigned RegIdxWidth = 4;

  localparam logic [7:0] CmdMemblk = 8'h01;
  localparam logic [7:0] CmdRegwr  = 8'h02;
  localparam logic [7:0] CmdRun    = 8'h03;
  localparam logic [7:0] CmdHalt   = 8'h04;

  typedef enum logic [3:0] {
    StIdle,
    StMAh,
    StMAl,
    StMCh,
    StMCl,
    StMDh,
    StMDl,
    StMWr,
    StRIdx,
    StRDh,
    StRDl,
    StRWr,
    StPH,
    StPL,
    StErr
`ifdef LOADER_CHECKSUM_EN
    ,
    StMCk
`endif
  } state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: captures the high byte of a big-endian 16-bit field and
// presents {hi, current byte} so the loader can latch the full word on the
// low-byte edge. With LOADER_CHECKSUM_EN it also keeps an 8-bit running sum.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   in_data_i       current host byte
//   hi_load_i       latch in_data_i as the high byte
//   sum_clear_i     clear running sum (LOADER_CHECKSUM_EN only)
//   sum_add_i       add in_data_i to running sum (LOADER_CHECKSUM_EN only)
//   word_o          {high byte, in_data_i}
//   sum_o           running sum (LOADER_CHECKSUM_EN only)
module word_assembler
  import loader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           in_data_i,
  input  logic                 hi_load_i,
`ifdef LOADER_CHECKSUM_EN
  input  logic                 sum_clear_i,
  input  logic                 sum_add_i,
  output logic [7:0]           sum_o,
`endif
  output logic [DataWidth-1:0] word_o
);

  logic [7:0] hi_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hi_q <= 8'h00;
    end else if (hi_load_i) begin
      hi_q <= in_data_i;
    end
  end

  assign word_o = {hi_q, in_data_i};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q <= 8'h00;
    end else if (sum_clear_i) begin
      sum_q <= 8'h00;
    end else if (sum_add_i) begin
      sum_q <= sum_q + in_data_i;
    end
  end

  assign sum_o = sum_q;
`endif

endmodule

// File: rtl/program_loader.sv
// program_loader: parses a host byte stream of MEMBLK / REGWR / RUN / HALT
// commands and drives the CPU memory and register write ports, start PC and
// run enable.
// Ports:
//   CLK, RESET                      clock, synchronous active-low reset
//   InData, InValid, InReady        host byte stream handshake
//   MemoryOperation, MemoryWrite,
//   MemoryAddress, MemWriteData     memory write port
//   RegisterOperation, RegisterWrite,
//   RegisterAddress, RegWriteData   register write port
//   ResetPC, Test                   CPU start PC and run enable
//   Busy, Error                     command in progress, sticky fault
// Optional feature macro: LOADER_CHECKSUM_EN (trailing MEMBLK checksum byte).
module program_loader
  import loader_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7:0]             InData,
  input  logic                   InValid,
  output logic                   InReady,
  output logic                   MemoryOperation,
  output logic                   MemoryWrite,
  output logic [DataWidth-1:0]   MemoryAddress,
  output logic [DataWidth-1:0]   MemWriteData,
  output logic                   RegisterOperation,
  output logic                   RegisterWrite,
  output logic [RegIdxWidth-1:0] RegisterAddress,
  output logic [DataWidth-1:0]   RegWriteData,
  output logic [DataWidth-1:0]   ResetPC,
  output logic                   Test,
  output logic                   Busy,
  output logic                   Error
);

  state_e                 state_q, state_d, blk_done;
  logic                   accept, hi_load;
  logic [DataWidth-1:0]   word, addr_q, cnt_q, wdata_q, rdata_q, pc_q;
  logic [RegIdxWidth-1:0] ridx_q;
  logic                   test_q;

`ifdef LOADER_CHECKSUM_EN
  logic       sum_clear, sum_add;
  logic [7:0] sum;
  assign blk_done = StMCk;
`else
  assign blk_done = StIdle;
`endif

  word_assembler u_word_assembler (
    .clk_i       (CLK),
    .rst_ni      (RESET),
    .in_data_i   (InData),
    .hi_load_i   (hi_load),
`ifdef LOADER_CHECKSUM_EN
    .sum_clear_i (sum_clear),
    .sum_add_i   (sum_add),
    .sum_o       (sum),
`endif
    .word_o      (word)
  );

  assign accept = InValid & InReady;

  always_comb begin
    state_d           = state_q;
    InReady           = 1'b1;
    MemoryWrite       = 1'b0;
    RegisterWrite     = 1'b0;
    MemoryOperation   = 1'b0;
    RegisterOperation = 1'b0;
    Busy              = 1'b1;
    Error             = 1'b0;
    hi_load           = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_clear         = 1'b0;
    sum_add           = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        Busy = 1'b0;
        if (accept) begin
          case (InData)
            CmdMemblk: begin
              state_d = StMAh;
`ifdef LOADER_CHECKSUM_EN
              sum_clear = 1'b1;
`endif
            end
            CmdRegwr: state_d = StRIdx;
            CmdRun:   state_d = StPH;
            CmdHalt:  state_d = StIdle;
            default:  state_d = StErr;
          endcase
        end
      end
      StMAh: begin
        MemoryOperation = 1'b1;
        hi_load         = accept;
        if (accept) state_d = StMAl;
      end
      StMAl: begin
        MemoryOperation = 1'b1;
        if (accept) state_d = StMCh;
      end
      StMCh: begin
        MemoryOperation = 1'b1;
        hi_load         = accept;
        if (accept) state_d = StMCl;
      end
      StMCl: begin
        MemoryOperation = 1'b1;
        if (accept) state_d = (word == '0) ? blk_done : StMDh;
      end
      StMDh: begin
        MemoryOperation = 1'b1;
        hi_load         = accept;
`ifdef LOADER_CHECKSUM_EN
        sum_add = accept;
`endif
        if (accept) state_d = StMDl;
      end
      StMDl: begin
        MemoryOperation = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum_add = accept;
`endif
        if (accept) state_d = StMWr;
      end
      StMWr: begin
        MemoryOperation = 1'b1;
        MemoryWrite     = 1'b1;
        InReady         = 1'b0;
        // cnt_q still holds the count before this write is retired
        state_d = (cnt_q == 16'd1) ? blk_done : StMDh;
      end
      StRIdx: begin
        RegisterOperation = 1'b1;
        if (accept) state_d = StRDh;
      end
      StRDh: begin
        RegisterOperation = 1'b1;
        hi_load           = accept;
        if (accept) state_d = StRDl;
      end
      StRDl: begin
        RegisterOperation = 1'b1;
        if (accept) state_d = StRWr;
      end
      StRWr: begin
        RegisterOperation = 1'b1;
        RegisterWrite     = 1'b1;
        InReady           = 1'b0;
        state_d           = StIdle;
      end
      StPH: begin
        hi_load = accept;
        if (accept) state_d = StPL;
      end
      StPL: begin
        if (accept) state_d = StIdle;
      end
      StErr: begin
        Busy  = 1'b0;
        Error = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      StMCk: begin
        if (accept) state_d = (InData == sum) ? StIdle : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ridx_q  <= '0;
      pc_q    <= '0;
      test_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StMWr) begin
        addr_q <= addr_q + 16'd1;
        cnt_q  <= cnt_q - 16'd1;
      end
      if (accept) begin
        case (state_q)
          StIdle: begin
            // Halt the CPU before any load command can write
            if (InData == CmdMemblk || InData == CmdRegwr || InData == CmdHalt) test_q <= 1'b0;
          end
          StMAl:  addr_q  <= word;
          StMCl:  cnt_q   <= word;
          StMDl:  wdata_q <= word;
          StRIdx: ridx_q  <= InData[RegIdxWidth-1:0];
          StRDl:  rdata_q <= word;
          StPL: begin
            pc_q   <= word;
            test_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign MemoryAddress   = addr_q;
  assign MemWriteData    = wdata_q;
  assign RegisterAddress = ridx_q;
  assign RegWriteData    = rdata_q;
  assign ResetPC         = pc_q;
  assign Test            = test_q;

endmodule
